snake_roll_ctrl: RTL and testbench

Parametrised intro/score display sequencer for the snake game LED matrix. It scrolls a stream of cell indices through an N-segment buffer during the START animation, then hands the display over to the live snake body, and flashes the body on WIN. It sits between the game FSM (state code), the intro index generator (head_index, step_tick) and the matrix renderer (snake_index, snake_en).

---
 rtl/snake_roll_ctrl.sv | 177 +++++++++++++++++
 tb/tb_snake_roll_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_roll_ctrl.sv
// Intro/score display sequencer: scrolls head_index through a SEG_NUM buffer in ROLL, shows snake_body in BODY, flashes it in WIN.
// Latency: snake_index and all flags are registered, one cycle after the inputs/state that produce them.
// Backpressure: none; step_tick is a fire-and-forget advance pulse and every tick is consumed the cycle it arrives.
//
// Ports:
//   sys_clk, sys_rst      clock and synchronous active-high reset
//   step_tick, head_index advance pulse and the index entering the buffer on that pulse
//   snake_body            live body segments (segment 0 in LSBs)
//   state, dir            game FSM code; insert end (0: top segment, 1: segment 0)
//   snake_index           registered display indices
//   snake_en/roll_en/win_en/roll_done/roll_timeout  status flags
//
// Optional feature macro SNAKE_ROLL_TIMEOUT_EN: ends ROLL after ROLL_MAX ticks without END_INDEX
// and raises the sticky roll_timeout flag. Without it roll_timeout is constant 0.
module snake_roll_ctrl #(
    parameter int SEG_NUM     = 8,
    parameter int IDX_W       = 6,
    parameter int STATE_W     = 5,
    parameter int IDLE_CODE   = 0,
    parameter int START_CODE  = 5,
    parameter int WIN_CODE    = 6,
    parameter int END_INDEX   = 63,
    parameter int FLASH_TICKS = 4,
    parameter int ROLL_MAX    = 64
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       step_tick,
    input  logic [IDX_W-1:0]           head_index,
    input  logic [SEG_NUM*IDX_W-1:0]   snake_body,
    input  logic [STATE_W-1:0]         state,
    input  logic                       dir,
    output logic [SEG_NUM*IDX_W-1:0]   snake_index,
    output logic                       snake_en,
    output logic                       roll_en,
    output logic                       win_en,
    output logic                       roll_done,
    output logic                       roll_timeout
);

    localparam int CNT_MAX = (FLASH_TICKS > ROLL_MAX) ? FLASH_TICKS : ROLL_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [STATE_W-1:0] IDLE_C  = STATE_W'(IDLE_CODE);
    localparam logic [STATE_W-1:0] START_C = STATE_W'(START_CODE);
    localparam logic [STATE_W-1:0] WIN_C   = STATE_W'(WIN_CODE);
    localparam logic [IDX_W-1:0]   END_C   = IDX_W'(END_INDEX);

    typedef enum logic [1:0] {S_IDLE, S_ROLL, S_BODY, S_WIN} fsm_t;

    fsm_t                             cur_st;
    fsm_t                             nxt_st;
    logic [SEG_NUM-1:0][IDX_W-1:0]    seg_q;
    logic [CNT_W-1:0]                 flash_cnt;
    logic                             phase;
    logic                             timeout_hit;

    logic [SEG_NUM*IDX_W-1:0]         idx_d;
    logic                             roll_en_d;
    logic                             snake_en_d;
    logic                             win_en_d;
    logic                             roll_done_d;

    logic                             roll_entry;
    logic                             win_entry;
    logic                             shift_en;

    assign roll_entry = (cur_st != S_ROLL) && (nxt_st == S_ROLL);
    assign win_entry  = (cur_st != S_WIN)  && (nxt_st == S_WIN);
    // A state change in the same cycle as the tick suppresses the shift.
    assign shift_en   = (cur_st == S_ROLL) && (nxt_st == S_ROLL) && step_tick;

`ifdef SNAKE_ROLL_TIMEOUT_EN
    logic [CNT_W-1:0] roll_cnt;

    // This tick is the ROLL_MAX-th one seen in ROLL.
    assign timeout_hit = (cur_st == S_ROLL) && step_tick && (roll_cnt == CNT_W'(ROLL_MAX - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            roll_cnt     <= '0;
            roll_timeout <= 1'b0;
        end else begin
            if (roll_entry) begin
                roll_cnt     <= '0;
                roll_timeout <= 1'b0;
            end else begin
                if (shift_en)
                    roll_cnt <= roll_cnt + CNT_W'(1);
                // ROLL->BODY that was not caused by END_INDEX can only be the timeout.
                if ((cur_st == S_ROLL) && (nxt_st == S_BODY) && (head_index != END_C))
                    roll_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign roll_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            cur_st <= S_IDLE;
        else
            cur_st <= nxt_st;
    end

    // Next-state logic, highest priority first
    always_comb begin
        nxt_st = cur_st;
        if (state == IDLE_C)
            nxt_st = S_IDLE;
        else if ((state == WIN_C) && ((cur_st == S_ROLL) || (cur_st == S_BODY)))
            nxt_st = S_WIN;
        else if ((cur_st == S_IDLE) && (state == START_C))
            nxt_st = S_ROLL;
        else if ((cur_st == S_ROLL) && step_tick && ((head_index == END_C) || timeout_hit))
            nxt_st = S_BODY;
    end

    // Output decode; snake_index follows the current state so the buffer is
    // still shown on the cycle roll_done pulses.
    always_comb begin
        case (cur_st)
            S_BODY:  idx_d = snake_body;
            S_WIN:   idx_d = phase ? snake_body : '0;
            default: idx_d = seg_q;
        endcase
        roll_en_d   = (nxt_st == S_ROLL);
        snake_en_d  = (nxt_st == S_BODY) || (nxt_st == S_WIN);
        win_en_d    = (nxt_st == S_WIN);
        roll_done_d = (cur_st == S_ROLL) && (nxt_st == S_BODY);
    end

    // Buffer, flash timing and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            seg_q       <= '0;
            flash_cnt   <= '0;
            phase       <= 1'b0;
            snake_index <= '0;
            roll_en     <= 1'b0;
            snake_en    <= 1'b0;
            win_en      <= 1'b0;
            roll_done   <= 1'b0;
        end else begin
            if (roll_entry)
                seg_q <= '0;
            else if (shift_en) begin
                if (dir)
                    seg_q <= {seg_q[SEG_NUM-2:0], head_index};
                else
                    seg_q <= {head_index, seg_q[SEG_NUM-1:1]};
            end

            if (win_entry) begin
                phase     <= 1'b1;
                flash_cnt <= '0;
            end else if ((cur_st == S_WIN) && step_tick) begin
                if (flash_cnt == CNT_W'(FLASH_TICKS - 1)) begin
                    phase     <= ~phase;
                    flash_cnt <= '0;
                end else begin
                    flash_cnt <= flash_cnt + CNT_W'(1);
                end
            end

            snake_index <= idx_d;
            roll_en     <= roll_en_d;
            snake_en    <= snake_en_d;
            win_en      <= win_en_d;
            roll_done   <= roll_done_d;
        end
    end

endmodule

// File: tb/tb_snake_roll_ctrl.sv
// Self-checking bench for snake_roll_ctrl: directed vector table, hand sequences for flash and
// long rolls, then random stimulus against a queue-based reference model.
// Honours SNAKE_ROLL_TIMEOUT_EN so the same bench fits either build.
module tb_snake_roll_ctrl;

    localparam int SEG_NUM = 8;
    localparam int IDX_W   = 6;
    localparam int W       = SEG_NUM * IDX_W;
    localparam int FT      = 4;
    localparam int RMAX    = 64;
`ifdef SNAKE_ROLL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_ROLL = 1;
    localparam int M_BODY = 2;
    localparam int M_WIN  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick;
    logic [IDX_W-1:0] hidx;
    logic [W-1:0]   body;
    logic [4:0]     st;
    logic           dir;
    logic [W-1:0]   snake_index;
    logic           snake_en, roll_en, win_en, roll_done, roll_timeout;

    snake_roll_ctrl dut (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .step_tick    (tick),
        .head_index   (hidx),
        .snake_body   (body),
        .state        (st),
        .dir          (dir),
        .snake_index  (snake_index),
        .snake_en     (snake_en),
        .roll_en      (roll_en),
        .win_en       (win_en),
        .roll_done    (roll_done),
        .roll_timeout (roll_timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    int          m_mode;
    int          m_seg[$];          // position k holds segment k
    bit          m_phase;
    int          m_flash_ticks;
    int          m_roll_ticks;
    bit          m_to;
    logic [W-1:0] e_idx;
    bit          e_roll, e_snake, e_win, e_done, e_to;

    function automatic logic [W-1:0] pack_model();
        logic [W-1:0] v = '0;
        for (int i = 0; i < SEG_NUM; i++)
            v = v | (W'(m_seg[i]) << (i * IDX_W));
        return v;
    endfunction

    function automatic void model_clear_buf();
        m_seg.delete();
        for (int i = 0; i < SEG_NUM; i++) m_seg.push_back(0);
    endfunction

    // Advances the model by one rising edge using the inputs currently applied.
    function automatic void model_edge();
        int nm;
        bit by_timeout;
        int s = int'(st);
        int h = int'(hidx);
        if (rst) begin
            m_mode = M_IDLE; model_clear_buf();
            m_phase = 0; m_flash_ticks = 0; m_roll_ticks = 0; m_to = 0;
            e_idx = '0; e_roll = 0; e_snake = 0; e_win = 0; e_done = 0; e_to = 0;
            return;
        end
        if (m_mode == M_BODY)     e_idx = body;
        else if (m_mode == M_WIN) e_idx = m_phase ? body : '0;
        else                      e_idx = pack_model();

        nm = m_mode;
        by_timeout = 0;
        if (s == 0) nm = M_IDLE;
        else if (s == 6 && (m_mode == M_ROLL || m_mode == M_BODY)) nm = M_WIN;
        else if (m_mode == M_IDLE && s == 5) nm = M_ROLL;
        else if (m_mode == M_ROLL && tick && h == 63) nm = M_BODY;
        else if (TO_EN && m_mode == M_ROLL && tick && m_roll_ticks + 1 == RMAX) begin
            nm = M_BODY; by_timeout = 1;
        end

        e_done = (m_mode == M_ROLL) && (nm == M_BODY);
        if (nm == M_ROLL && m_mode != M_ROLL) begin
            model_clear_buf(); m_roll_ticks = 0; m_to = 0;
        end else if (m_mode == M_ROLL && nm == M_ROLL && tick) begin
            m_roll_ticks++;
            if (dir) begin void'(m_seg.pop_back()); m_seg.push_front(h); end
            else     begin void'(m_seg.pop_front()); m_seg.push_back(h); end
        end
        if (by_timeout) m_to = 1;

        if (nm == M_WIN && m_mode != M_WIN) begin
            m_phase = 1; m_flash_ticks = 0;
        end else if (m_mode == M_WIN && tick) begin
            m_flash_ticks++;
            if (m_flash_ticks == FT) begin m_phase = !m_phase; m_flash_ticks = 0; end
        end

        m_mode  = nm;
        e_roll  = (nm == M_ROLL);
        e_snake = (nm == M_BODY) || (nm == M_WIN);
        e_win   = (nm == M_WIN);
        e_to    = TO_EN ? m_to : 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".snake_index"},  64'(snake_index), 64'(e_idx));
        chk({tag, ".roll_en"},      64'(roll_en),     64'(e_roll));
        chk({tag, ".snake_en"},     64'(snake_en),    64'(e_snake));
        chk({tag, ".win_en"},       64'(win_en),      64'(e_win));
        chk({tag, ".roll_done"},    64'(roll_done),   64'(e_done));
        chk({tag, ".roll_timeout"}, 64'(roll_timeout),64'(e_to));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit           rst;
        bit           tick;
        int           h;
        int           s;
        bit           d;
        logic [63:0]  idx;
        bit           roll, snake, win, done;
    } vec_t;

    function automatic vec_t mk(bit r, bit t, int h, int s, bit d, logic [63:0] idx,
                                bit ro, bit sn, bit wi, bit dn);
        vec_t v;
        v.rst = r; v.tick = t; v.h = h; v.s = s; v.d = d; v.idx = idx;
        v.roll = ro; v.snake = sn; v.win = wi; v.done = dn;
        return v;
    endfunction

    function automatic logic [63:0] sv(int pos, int val);
        return 64'(val) << (pos * IDX_W);
    endfunction

    initial begin
        vec_t        tbl[24];
        logic [63:0] top321, top1, top21, bot321, bot1, bot21, bc;
        bc     = 64'h0000_A5A5_1234_5678;
        top1   = sv(7, 1);
        top21  = sv(7, 2) | sv(6, 1);
        top321 = sv(7, 3) | sv(6, 2) | sv(5, 1);
        bot1   = sv(0, 1);
        bot21  = sv(0, 2) | sv(1, 1);
        bot321 = sv(0, 3) | sv(1, 2) | sv(2, 1);

        //              rst tk  h  st d  idx     ro sn wi dn
        tbl[0]  = mk(1, 0, 0, 0, 0, 64'd0,  0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 5, 0, 64'd0,  1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 5, 0, 64'd0,  1, 0, 0, 0);
        tbl[3]  = mk(0, 1, 2, 5, 0, top1,   1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 3, 5, 0, top21,  1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 9, 5, 0, top321, 1, 0, 0, 0);
        tbl[6]  = mk(0, 1,63, 5, 0, top321, 0, 1, 0, 1);
        tbl[7]  = mk(0, 0, 0, 5, 0, bc,     0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, bc,     0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 4, 6, 0, top321, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 5, 1, top321, 1, 0, 0, 0);
        tbl[11] = mk(0, 1, 1, 5, 1, 64'd0,  1, 0, 0, 0);
        tbl[12] = mk(0, 1, 2, 5, 1, bot1,   1, 0, 0, 0);
        tbl[13] = mk(0, 1, 3, 5, 1, bot21,  1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 5, 1, bot321, 1, 0, 0, 0);
        tbl[15] = mk(0, 1, 9, 6, 1, bot321, 0, 1, 1, 0);
        tbl[16] = mk(0, 0, 0, 6, 1, bc,     0, 1, 1, 0);
        tbl[17] = mk(0, 0, 0, 0, 1, bc,     0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 5, 0, bot321, 1, 0, 0, 0);
        tbl[19] = mk(0, 1, 7, 5, 0, 64'd0,  1, 0, 0, 0);
        tbl[20] = mk(1, 1, 8, 5, 0, 64'd0,  0, 0, 0, 0);
        tbl[21] = mk(1, 0, 0, 5, 0, 64'd0,  0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 0, 0, 64'd0,  0, 0, 0, 0);
        tbl[23] = mk(0, 1, 5, 6, 0, 64'd0,  0, 0, 0, 0);

        rst = 1; tick = 0; hidx = '0; st = '0; dir = 0; body = bc[W-1:0];

        for (int i = 0; i < 24; i++) begin
            rst = tbl[i].rst; tick = tbl[i].tick; hidx = IDX_W'(tbl[i].h);
            st = 5'(tbl[i].s); dir = tbl[i].d;
            step();
            chk($sformatf("vec%0d.snake_index", i), 64'(snake_index), tbl[i].idx);
            chk($sformatf("vec%0d.roll_en", i),     64'(roll_en),     64'(tbl[i].roll));
            chk($sformatf("vec%0d.snake_en", i),    64'(snake_en),    64'(tbl[i].snake));
            chk($sformatf("vec%0d.win_en", i),      64'(win_en),      64'(tbl[i].win));
            chk($sformatf("vec%0d.roll_done", i),   64'(roll_done),   64'(tbl[i].done));
            chk($sformatf("vec%0d.roll_timeout", i),64'(roll_timeout),64'd0);
        end

        // Flash: enter WIN on a tick, then tick every cycle and follow body/zero phases.
        tick = 0; st = 5'd5; step(); chk_model("flash_enter_roll");
        tick = 1; hidx = 6'd11; st = 5'd6; step(); chk_model("flash_win_entry");
        for (int i = 0; i < 20; i++) begin
            body = W'({$urandom, $urandom});
            tick = (i % 5) != 3;
            step(); chk_model($sformatf("flash%0d", i));
        end
        st = 5'd0; tick = 0; step(); chk_model("flash_to_idle");

        // Long roll without END_INDEX: timeout build goes to BODY after RMAX ticks.
        st = 5'd5; step(); chk_model("long_entry");
        for (int i = 0; i < RMAX + 6; i++) begin
            tick = 1; hidx = IDX_W'(i % 60); dir = i[0];
            step(); chk_model($sformatf("long%0d", i));
        end
        tick = 0; st = 5'd0; step(); chk_model("long_idle");
        st = 5'd5; step(); chk_model("long_reentry");
        st = 5'd9; step(); chk_model("long_other_code");

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            tick = $urandom_range(0, 1) == 1;
            hidx = ($urandom_range(0, 19) == 0) ? 6'd63 : IDX_W'($urandom_range(0, 62));
            dir  = $urandom_range(0, 1) == 1;
            body = W'({$urandom, $urandom});
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 5))
                    0:       st = 5'd0;
                    1, 2:    st = 5'd5;
                    3:       st = 5'd6;
                    default: st = 5'($urandom_range(0, 31));
                endcase
            end
            step(); chk_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
